// File: rtl/cnt_share_pkg.sv
// Shared state encoding and default widths for the counter-sharing arbiter.
// Pure declarations: no latency and no backpressure.
package cnt_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 2;
    localparam int LENW_DEF = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after i_ptr, wrapping.
// Zero latency; no backpressure, the caller decides when to consume the pick.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    int w_j;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        w_j      = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!o_vld && i_req[IW'(w_j)]) begin
                o_vld               = 1'b1;
                o_idx               = IW'(w_j);
                o_onehot[IW'(w_j)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin owner of one shared counter: drives its increment line for len cycles, then reports count and consistency.
// Latency: request sampled at edge e -> done in the cycle after edge e+len+1; requesters wait on a level req until granted.
module cnt_share_arb
    import cnt_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LENW-1:0] len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        result,
    output logic                 err,
    output logic                 busy,
    output logic                 cnt_in,
    input  logic [CW-1:0]        cnt_count
);

    localparam int IW = $clog2(NREQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_rem;
    logic [CW-1:0]   r_base;
    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_vld;
    logic [LENW-1:0] w_pick_len;
    logic [CW-1:0]   w_exp;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    assign w_pick_len = len[w_pick_idx*LENW +: LENW];
    // Truncating len first keeps the expected value modulo 2^CW.
    assign w_exp      = r_base + CW'(r_len);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = (w_pick_len == '0) ? ST_SETTLE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_rem == LENW'(1)) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs follow the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr  <= '0;
            r_idx  <= '0;
            r_len  <= '0;
            r_rem  <= '0;
            r_base <= '0;
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            err    <= 1'b0;
            busy   <= 1'b0;
            cnt_in <= 1'b0;
        end else begin
            done   <= '0;
            busy   <= (w_state_nxt != ST_IDLE);
            cnt_in <= (w_state_nxt == ST_DRIVE);
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_idx  <= w_pick_idx;
                        r_len  <= w_pick_len;
                        r_rem  <= w_pick_len;
                        r_base <= cnt_count;
                        gnt    <= w_pick_oh;
                    end
                end
                ST_DRIVE: begin
                    r_rem <= r_rem - 1'b1;
                end
                ST_SETTLE: begin
                    result <= cnt_count;
                    err    <= (cnt_count != w_exp);
                    done   <= gnt;
                end
                ST_DONE: begin
                    gnt   <= '0;
                    r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
